// File: rtl/ro_puf_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ro_puf_pkg - shared FSM encoding and width helper for the RO-PUF engine
// Rev 1.0
// ----------------------------------------------------------------------------
package ro_puf_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETTLE  = 3'd1,
    MEASURE = 3'd2,
    COMPARE = 3'd3,
    DONE    = 3'd4
  } state_t;

  // Smallest w with 2**w >= value (0 for value <= 1).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ro_edge_counter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ro_edge_counter - synchronised rising-edge counter for one asynchronous RO
// Rev 1.0
// ----------------------------------------------------------------------------
module ro_edge_counter #(
  parameter int CNT_W = 12
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ro,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count
);

  // sync[1:0] is the two-flop synchroniser, sync[2] the edge-detect history.
  logic [2:0] sync;
  logic       rise;

  assign rise = sync[1] & ~sync[2];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync  <= '0;
      count <= '0;
    end else begin
      sync <= {sync[1:0], ro};
      if (clear) begin
        count <= '0;
      end else if (enable && rise && (count != '1)) begin
        count <= count + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ro_puf_engine.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ro_puf_engine - evaluates N_BITS RO challenge pairs into a response word
// Rev 1.0
// ----------------------------------------------------------------------------
module ro_puf_engine
  import ro_puf_pkg::*;
#(
  parameter int N_RO       = 16,
  parameter int SEL_W      = 4,
  parameter int CNT_W      = 12,
  parameter int WINDOW     = 4095,
  parameter int SETTLE_CYC = 4,
  parameter int N_BITS     = 8,
  parameter int MARGIN     = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [N_RO-1:0]           ro_in,
  input  logic                      start,
  input  logic                      abort,
  input  logic [2*SEL_W*N_BITS-1:0] challenge,
  output logic                      ro_enable,
  output logic                      busy,
  output logic                      done,
  output logic [N_BITS-1:0]         response,
  output logic [N_BITS-1:0]         unstable,
  output logic                      err,
  output logic [CNT_W-1:0]          cnt1_out,
  output logic [CNT_W-1:0]          cnt2_out
);

  localparam int PAIR_W  = 2 * SEL_W;
  localparam int IDX_W   = (N_BITS > 1) ? clog2(N_BITS) : 1;
  localparam int TMR_MAX = (WINDOW > SETTLE_CYC) ? WINDOW : SETTLE_CYC;
  localparam int TMR_W   = (TMR_MAX > 1) ? clog2(TMR_MAX) : 1;

  if ((N_RO < 2) || (clog2(N_RO) > SEL_W)) begin : g_bad_sel_w
    $error("ro_puf_engine: SEL_W too narrow for N_RO");
  end

  state_t                    state, state_nxt;
  logic [2*SEL_W*N_BITS-1:0] chal_q;
  logic [IDX_W-1:0]          idx, idx_nxt;
  logic [TMR_W-1:0]          tmr;
  logic [PAIR_W-1:0]         cur_pair, nxt_pair;
  logic [SEL_W-1:0]          sel1, sel2;
  logic                      ro_mux1, ro_mux2;
  logic                      last, cur_ok, start_ok, ge;
  logic                      cnt_clr, cnt_en;
  logic [CNT_W:0]            diff;
  logic [CNT_W-1:0]          cnt1, cnt2;

  function automatic logic pair_ok(input logic [PAIR_W-1:0] p);
    logic [SEL_W-1:0] a, b;
    a = p[SEL_W-1:0];
    b = p[PAIR_W-1:SEL_W];
    return (a != b) && (32'(a) < N_RO) && (32'(b) < N_RO);
  endfunction

  assign last     = (idx == IDX_W'(N_BITS - 1));
  assign idx_nxt  = last ? '0 : idx + 1'b1;
  assign cur_pair = chal_q[idx * PAIR_W +: PAIR_W];
  assign nxt_pair = chal_q[idx_nxt * PAIR_W +: PAIR_W];
  assign cur_ok   = pair_ok(cur_pair);
  assign sel1     = cur_pair[SEL_W-1:0];
  assign sel2     = cur_pair[PAIR_W-1:SEL_W];
  assign start_ok = (state == IDLE) && start && !abort;

  always_comb begin
    ro_mux1 = 1'b0;
    ro_mux2 = 1'b0;
    for (int i = 0; i < N_RO; i++) begin
      if (sel1 == SEL_W'(i)) ro_mux1 = ro_in[i];
      if (sel2 == SEL_W'(i)) ro_mux2 = ro_in[i];
    end
  end

  assign cnt_clr = (state == SETTLE);
  assign cnt_en  = (state == MEASURE);

  ro_edge_counter #(.CNT_W(CNT_W)) u_cnt1 (
    .clock(clock), .reset(reset), .ro(ro_mux1),
    .clear(cnt_clr), .enable(cnt_en), .count(cnt1)
  );

  ro_edge_counter #(.CNT_W(CNT_W)) u_cnt2 (
    .clock(clock), .reset(reset), .ro(ro_mux2),
    .clear(cnt_clr), .enable(cnt_en), .count(cnt2)
  );

  // One extra bit keeps the magnitude from wrapping.
  assign ge   = (cnt1 >= cnt2);
  assign diff = ge ? ({1'b0, cnt1} - {1'b0, cnt2}) : ({1'b0, cnt2} - {1'b0, cnt1});

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Illegal pairs bypass SETTLE/MEASURE and are resolved in a single COMPARE.
  always_comb begin
    state_nxt = state;
    ro_enable = 1'b0;
    busy      = (state != IDLE);
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = pair_ok(challenge[PAIR_W-1:0]) ? SETTLE : COMPARE;
      end
      SETTLE: begin
        ro_enable = 1'b1;
        if (tmr == TMR_W'(SETTLE_CYC - 1)) state_nxt = MEASURE;
      end
      MEASURE: begin
        ro_enable = 1'b1;
        if (tmr == TMR_W'(WINDOW - 1)) state_nxt = COMPARE;
      end
      COMPARE: begin
        ro_enable = 1'b1;
        if (last) state_nxt = DONE;
        else      state_nxt = pair_ok(nxt_pair) ? SETTLE : COMPARE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      chal_q   <= '0;
      idx      <= '0;
      tmr      <= '0;
      response <= '0;
      unstable <= '0;
      err      <= 1'b0;
    end else begin
      if (((state == SETTLE) || (state == MEASURE)) && (state_nxt == state)) tmr <= tmr + 1'b1;
      else tmr <= '0;

      if (start_ok) begin
        chal_q   <= challenge;
        idx      <= '0;
        response <= '0;
        unstable <= '0;
        err      <= 1'b0;
      end

      if ((state == COMPARE) && !abort) begin
        if (!cur_ok) begin
          response[idx] <= 1'b0;
          unstable[idx] <= 1'b1;
          err           <= 1'b1;
        end else begin
          response[idx] <= ge;
          unstable[idx] <= (32'(diff) < MARGIN);
        end
        idx <= idx_nxt;
      end
    end
  end

  assign cnt1_out = cnt1;
  assign cnt2_out = cnt2;

endmodule
`default_nettype wire

// File: tb/tb_ro_puf_engine.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_ro_puf_engine - directed vectors for ro_puf_engine (main and saturating build)
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ro_puf_engine;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] challenge = '0;
  logic [15:0] ro = '0;

  logic        en_a, busy_a, done_a, err_a;
  logic [3:0]  resp_a, unst_a;
  logic [11:0] c1_a, c2_a;
  logic        en_b, busy_b, done_b, err_b;
  logic [3:0]  resp_b, unst_b;
  logic [3:0]  c1_b, c2_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;
  int per [16];

  int   da_total = 0, da_at = 0, db_total = 0, db_at = 0;
  logic en_done_a = 1'b1;
  int   r_seen_a, r_cyc_a, r_seen_b, r_cyc_b;

  typedef struct {
    logic [31:0] ch;
    logic [3:0]  resp;
    logic [3:0]  unst;
    logic        err;
    int          dcyc;
    int          c1;
    int          c2;
  } vec_t;
  vec_t tv [4];

  ro_puf_engine #(.N_RO(16), .SEL_W(4), .CNT_W(12), .WINDOW(64), .SETTLE_CYC(4),
                  .N_BITS(4), .MARGIN(4)) dut_a (
    .clock(clock), .reset(reset), .ro_in(ro), .start(start), .abort(abort),
    .challenge(challenge), .ro_enable(en_a), .busy(busy_a), .done(done_a),
    .response(resp_a), .unstable(unst_a), .err(err_a), .cnt1_out(c1_a), .cnt2_out(c2_a)
  );

  ro_puf_engine #(.N_RO(12), .SEL_W(4), .CNT_W(4), .WINDOW(64), .SETTLE_CYC(4),
                  .N_BITS(4), .MARGIN(4)) dut_b (
    .clock(clock), .reset(reset), .ro_in(ro[11:0]), .start(start), .abort(abort),
    .challenge(challenge), .ro_enable(en_b), .busy(busy_b), .done(done_b),
    .response(resp_b), .unstable(unst_b), .err(err_b), .cnt1_out(c1_b), .cnt2_out(c2_b)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Square-wave RO model: period per[i] clocks, 0 means stuck low.
  always @(negedge clock) begin
    for (int i = 0; i < 16; i++) begin
      if (per[i] == 0) ro[i] <= 1'b0;
      else             ro[i] <= ((cyc % per[i]) < (per[i] / 2));
    end
  end

  always @(negedge clock) begin
    if (done_a) begin
      da_total  <= da_total + 1;
      da_at     <= cyc;
      en_done_a <= en_a;
    end
    if (done_b) begin
      db_total <= db_total + 1;
      db_at    <= cyc;
    end
  end

  function automatic logic [31:0] mk(input int a0, b0, a1, b1, a2, b2, a3, b3);
    return {4'(b3), 4'(a3), 4'(b2), 4'(a2), 4'(b1), 4'(a1), 4'(b0), 4'(a0)};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Start a run; optionally re-pulse start with another challenge mid-run.
  task automatic run(input logic [31:0] ch, input int extra_at, input logic [31:0] alt);
    int base_a, base_b, n;
    challenge = ch;
    @(negedge clock);
    start  = 1'b1;
    base_a = da_total;
    base_b = db_total;
    @(negedge clock);
    start = 1'b0;
    t0    = cyc - 1;
    n     = 1;
    while ((busy_a || busy_b) && (n < 2000)) begin
      @(negedge clock);
      n++;
      if (n == extra_at) begin
        start     = 1'b1;
        challenge = alt;
      end else begin
        start = 1'b0;
      end
    end
    if (n >= 2000) chk("run timeout", 32'(n), 32'(0));
    @(negedge clock);
    start    = 1'b0;
    r_seen_a = da_total - base_a;
    r_cyc_a  = da_at - t0;
    r_seen_b = db_total - base_b;
    r_cyc_b  = db_at - t0;
  endtask

  task automatic check_vec(input int i);
    chk($sformatf("v%0d response", i), 32'(resp_a), 32'(tv[i].resp));
    chk($sformatf("v%0d unstable", i), 32'(unst_a), 32'(tv[i].unst));
    chk($sformatf("v%0d err", i), 32'(err_a), 32'(tv[i].err));
    chk($sformatf("v%0d done cycle", i), 32'(r_cyc_a), 32'(tv[i].dcyc));
    chk($sformatf("v%0d done pulses", i), 32'(r_seen_a), 32'(1));
    chk($sformatf("v%0d ro_enable at done", i), 32'(en_done_a), 32'(0));
    chk($sformatf("v%0d cnt1_out", i), 32'(c1_a), 32'(tv[i].c1));
    chk($sformatf("v%0d cnt2_out", i), 32'(c2_a), 32'(tv[i].c2));
  endtask

  initial begin
    for (int i = 0; i < 16; i++) per[i] = 10;
    per[0] = 4;  per[1] = 6;  per[2] = 6;  per[4] = 2;  per[5] = 0;
    per[6] = 12; per[7] = 16; per[8] = 32; per[15] = 8;

    // Exact counts over 64 cycles: P4->16, P8->8, P16->4, P32->2, P2->32.
    tv[0] = '{mk(0,15, 15,0, 1,2, 7,0),   4'b0101, 4'b0100, 1'b0, 277, 4, 16};
    tv[1] = '{mk(3,3, 0,5, 5,0, 7,5),     4'b1010, 4'b0001, 1'b1, 209, 4, 0};
    tv[2] = '{mk(0,0, 1,1, 2,2, 15,15),   4'b0000, 4'b1111, 1'b1, 5,   4, 0};
    tv[3] = '{mk(4,0, 15,7, 7,15, 7,8),   4'b1011, 4'b1000, 1'b0, 277, 4, 2};

    repeat (3) @(negedge clock);
    chk("reset busy", 32'(busy_a), 32'(0));
    chk("reset ro_enable", 32'(en_a), 32'(0));
    chk("reset done", 32'(done_a), 32'(0));
    chk("reset response", 32'(resp_a), 32'(0));
    chk("reset unstable", 32'(unst_a), 32'(0));
    chk("reset err", 32'(err_a), 32'(0));
    chk("reset cnt1", 32'(c1_a), 32'(0));
    chk("reset cnt2", 32'(c2_a), 32'(0));
    reset = 1'b1;
    repeat (2) @(negedge clock);

    for (int i = 0; i < 4; i++) begin
      run(tv[i].ch, 0, '0);
      check_vec(i);
    end

    // Narrow build: out-of-range select and 4-bit saturation.
    run(mk(4,5, 5,4, 2,15, 4,0), 0, '0);
    chk("b response", 32'(resp_b), 32'(4'b1001));
    chk("b unstable", 32'(unst_b), 32'(4'b1100));
    chk("b err", 32'(err_b), 32'(1));
    chk("b done cycle", 32'(r_cyc_b), 32'(209));
    chk("b cnt1 saturated", 32'(c1_b), 32'(15));
    chk("b cnt2 saturated", 32'(c2_b), 32'(15));

    // Abort 10 cycles into MEASURE of pair 2 (MEASURE starts at edge 75).
    challenge = tv[1].ch;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    t0    = cyc - 1;
    begin
      int base, n;
      base = da_total;
      n    = 0;
      while ((cyc - t0 < 84) && (n < 200)) begin
        @(negedge clock);
        n++;
      end
      abort = 1'b1;
      @(negedge clock);
      abort = 1'b0;
      chk("abort busy", 32'(busy_a), 32'(0));
      chk("abort ro_enable", 32'(en_a), 32'(0));
      repeat (80) @(negedge clock);
      chk("abort no done", 32'(da_total - base), 32'(0));
      chk("abort response kept", 32'(resp_a), 32'(4'b0010));
      chk("abort unstable kept", 32'(unst_a), 32'(4'b0001));
      chk("abort err kept", 32'(err_a), 32'(1));
    end

    challenge = tv[3].ch;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("restart response cleared", 32'(resp_a), 32'(0));
    chk("restart unstable cleared", 32'(unst_a), 32'(0));
    chk("restart err cleared", 32'(err_a), 32'(0));
    chk("restart busy", 32'(busy_a), 32'(1));

    // Asynchronous reset in the middle of MEASURE.
    repeat (40) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("async reset busy", 32'(busy_a), 32'(0));
    chk("async reset ro_enable", 32'(en_a), 32'(0));
    chk("async reset cnt1", 32'(c1_a), 32'(0));
    chk("async reset busy b", 32'(busy_b), 32'(0));
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // A second start while busy must not disturb the running evaluation.
    run(tv[0].ch, 50, tv[2].ch);
    check_vec(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
